uart_rx_frame_ctrl: RTL and testbench

//   Frame controller behind the UART byte receiver.
//   - Consumes the receiver's one-cycle byte strobe plus data.
//   - Frame format: HEADER, LEN, LEN payload bytes, optional checksum.
//   - Stores the payload in a small register buffer; reports valid/error frames by pulse.
//   - Sits between uart receiver and the register/command logic that reads payloads.

---
 rtl/uart_rx_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame controller behind the UART byte receiver. Parses
//   HEADER, LEN, LEN payload bytes and an optional checksum byte. The payload
//   is kept in a small register buffer that is read through a registered
//   port. Accepted and rejected frames are reported with one-cycle pulses.
//   Optional feature macro: UART_FRAME_CHECKSUM_EN
//   (defined: CHK state and running 8-bit sum of LEN plus payload present).
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_irq,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        frame_len,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int                TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TIMER_ONE   = TW'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE     = ADDR_W'(1);
  localparam logic [7:0]        MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [ADDR_W:0]   MAX_LEN_A   = (ADDR_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
`ifdef UART_FRAME_CHECKSUM_EN
    CHK     = 2'd3,
`endif
    PAYLOAD = 2'd2
  } state_t;

  state_t              state_r;
  logic [7:0]          len_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [TW-1:0]       timer_r;
  logic [7:0]          buf_r [MAX_LEN];
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]          sum_r;
`endif

  // Registered read port of the payload buffer; out-of-range addresses read 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= 8'h00;
    end else if ({1'b0, rd_addr} < MAX_LEN_A) begin
      rd_data <= buf_r[rd_addr];
    end else begin
      rd_data <= 8'h00;
    end
  end

  // Frame FSM: byte parsing, buffer writes, inter-byte timeout and result pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      len_r       <= 8'h00;
      idx_r       <= '0;
      timer_r     <= '0;
      frame_len   <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_r       <= 8'h00;
`endif
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_r[i] <= 8'h00;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (state_r == IDLE) begin
        timer_r <= '0;
        if (rx_irq && (rx_data == HEADER)) begin
          state_r <= LEN;
          busy    <= 1'b1;
        end else begin
          busy    <= 1'b0;
        end
      end else if (!rx_irq) begin
        // No byte this cycle: age the frame and abandon it on expiry.
        if (timer_r == TIMER_LAST) begin
          frame_err <= 1'b1;
          state_r   <= IDLE;
          busy      <= 1'b0;
          timer_r   <= '0;
        end else begin
          timer_r   <= timer_r + TIMER_ONE;
        end
      end else begin
        // A byte arrived; it always wins over a coincident expiry.
        timer_r <= '0;
        case (state_r)
          LEN: begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              state_r   <= IDLE;
              busy      <= 1'b0;
            end else begin
              len_r     <= rx_data;
              idx_r     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              sum_r     <= rx_data;
`endif
              state_r   <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            buf_r[idx_r] <= rx_data;
            idx_r        <= idx_r + IDX_ONE;
`ifdef UART_FRAME_CHECKSUM_EN
            sum_r        <= sum_r + rx_data;
            if (8'(idx_r) == (len_r - 8'd1)) begin
              state_r <= CHK;
            end else begin
              state_r <= PAYLOAD;
            end
`else
            if (8'(idx_r) == (len_r - 8'd1)) begin
              frame_valid <= 1'b1;
              frame_len   <= len_r;
              state_r     <= IDLE;
              busy        <= 1'b0;
            end else begin
              state_r     <= PAYLOAD;
            end
`endif
          end
`ifdef UART_FRAME_CHECKSUM_EN
          CHK: begin
            if (rx_data == sum_r) begin
              frame_valid <= 1'b1;
              frame_len   <= len_r;
            end else begin
              frame_err   <= 1'b1;
            end
            state_r <= IDLE;
            busy    <= 1'b0;
          end
`endif
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (short TIMEOUT so expiry is reachable).
module tb_uart_rx_frame_ctrl;

  localparam int TO = 20;

  logic       clk;
  logic       rst;
  logic       rx_irq;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] frame_len;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_len;

  uart_rx_frame_ctrl #(
    .HEADER  (8'hAA),
    .MAX_LEN (16),
    .ADDR_W  (4),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_irq      (rx_irq),
    .rx_data     (rx_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One byte strobe: set at a negedge, captured at the next posedge,
  // returns at the following negedge where registered results are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_irq  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_irq  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] expv);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, {8'h00, rd_data}, {8'h00, expv});
  endtask

  initial begin
    rst     = 1'b0;
    rx_irq  = 1'b0;
    rx_data = 8'h00;
    rd_addr = 4'd0;
    exp_len = 8'h00;
    wait_cycles(3);
    check("rst_rd_data", {8'h00, rd_data}, 16'h0000);
    check("rst_frame_len", {8'h00, frame_len}, 16'h0000);
    check("rst_valid", {15'h0, frame_valid}, 16'h0000);
    check("rst_err", {15'h0, frame_err}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    rst = 1'b1;
    wait_cycles(1);

`ifdef UART_FRAME_CHECKSUM_EN
    // Good checksummed frame: 03+11+22+33 = 69.
    send_byte(8'hAA);
    check("t1_busy_hdr", {15'h0, busy}, 16'h0001);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t1_busy_pre_chk", {15'h0, busy}, 16'h0001);
    check("t1_valid_pre_chk", {15'h0, frame_valid}, 16'h0000);
    send_byte(8'h69);
    check("t1_valid", {15'h0, frame_valid}, 16'h0001);
    check("t1_err", {15'h0, frame_err}, 16'h0000);
    check("t1_len", {8'h00, frame_len}, 16'h0003);
    check("t1_busy", {15'h0, busy}, 16'h0000);
    wait_cycles(1);
    check("t1_valid_one_cycle", {15'h0, frame_valid}, 16'h0000);
    read_chk("t1_rd0", 4'd0, 8'h11);
    read_chk("t1_rd1", 4'd1, 8'h22);
    read_chk("t1_rd2", 4'd2, 8'h33);
    exp_len = 8'h03;
    // Bad checksum 68.
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h68);
    check("t2_err", {15'h0, frame_err}, 16'h0001);
    check("t2_valid", {15'h0, frame_valid}, 16'h0000);
    check("t2_len_held", {8'h00, frame_len}, {8'h00, exp_len});
    wait_cycles(1);
    check("t2_err_one_cycle", {15'h0, frame_err}, 16'h0000);
`else
    // Plain frame: valid right after last payload byte.
    send_byte(8'hAA);
    check("t6_busy_hdr", {15'h0, busy}, 16'h0001);
    send_byte(8'h02);
    send_byte(8'h11);
    check("t6_valid_early", {15'h0, frame_valid}, 16'h0000);
    send_byte(8'h22);
    check("t6_valid", {15'h0, frame_valid}, 16'h0001);
    check("t6_err", {15'h0, frame_err}, 16'h0000);
    check("t6_len", {8'h00, frame_len}, 16'h0002);
    check("t6_busy", {15'h0, busy}, 16'h0000);
    wait_cycles(1);
    check("t6_valid_one_cycle", {15'h0, frame_valid}, 16'h0000);
    read_chk("t6_rd0", 4'd0, 8'h11);
    read_chk("t6_rd1", 4'd1, 8'h22);
    exp_len = 8'h02;
`endif

    // Bad lengths 0 and 17.
    send_byte(8'hAA);
    send_byte(8'h00);
    check("t3_len0_err", {15'h0, frame_err}, 16'h0001);
    check("t3_len0_busy", {15'h0, busy}, 16'h0000);
    send_byte(8'hAA);
    send_byte(8'h11);
    check("t3_len17_err", {15'h0, frame_err}, 16'h0001);
    check("t3_len17_valid", {15'h0, frame_valid}, 16'h0000);
    check("t3_len17_busy", {15'h0, busy}, 16'h0000);
    check("t3_len_held", {8'h00, frame_len}, {8'h00, exp_len});
    // Header value inside a frame is data: AA 02 AA 01 [AD].
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'h01);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hAD);
`endif
    check("t3_hdr_data_valid", {15'h0, frame_valid}, 16'h0001);
    check("t3_hdr_data_len", {8'h00, frame_len}, 16'h0002);
    read_chk("t3_hdr_data_rd0", 4'd0, 8'hAA);
    // Maximum length 16: bytes 00..0F, checksum 10+78 = 88.
    send_byte(8'hAA);
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h88);
`endif
    check("t3_max_valid", {15'h0, frame_valid}, 16'h0001);
    check("t3_max_len", {8'h00, frame_len}, 16'h0010);
    read_chk("t3_max_rd15", 4'd15, 8'h0F);
    exp_len = 8'h10;

    // Timeout expiry.
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    wait_cycles(TO - 1);
    check("t4_no_err_before", {15'h0, frame_err}, 16'h0000);
    check("t4_busy_before", {15'h0, busy}, 16'h0001);
    wait_cycles(1);
    check("t4_err_at_expiry", {15'h0, frame_err}, 16'h0001);
    check("t4_busy_after", {15'h0, busy}, 16'h0000);
    check("t4_len_held", {8'h00, frame_len}, {8'h00, exp_len});
    // Byte landing on the expiry cycle is accepted.
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    wait_cycles(TO - 2);
    send_byte(8'h22);
    check("t4_race_no_err", {15'h0, frame_err}, 16'h0000);
`ifdef UART_FRAME_CHECKSUM_EN
    check("t4_race_busy", {15'h0, busy}, 16'h0001);
    send_byte(8'h35);
`endif
    check("t4_race_valid", {15'h0, frame_valid}, 16'h0001);
    check("t4_race_len", {8'h00, frame_len}, 16'h0002);

    // Noise ignored in IDLE, then one-byte frame.
    send_byte(8'h55);
    send_byte(8'h00);
    check("t5_noise_busy", {15'h0, busy}, 16'h0000);
    check("t5_noise_err", {15'h0, frame_err}, 16'h0000);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h7E);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h7F);
`endif
    check("t5_valid", {15'h0, frame_valid}, 16'h0001);
    check("t5_len", {8'h00, frame_len}, 16'h0001);
    read_chk("t5_rd0", 4'd0, 8'h7E);
    // Reset in the middle of a payload.
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    rst = 1'b0;
    wait_cycles(1);
    check("t5_rst_rd_data", {8'h00, rd_data}, 16'h0000);
    check("t5_rst_len", {8'h00, frame_len}, 16'h0000);
    check("t5_rst_valid", {15'h0, frame_valid}, 16'h0000);
    check("t5_rst_err", {15'h0, frame_err}, 16'h0000);
    check("t5_rst_busy", {15'h0, busy}, 16'h0000);
    rst = 1'b1;
    wait_cycles(TO + 2);
    check("t5_post_rst_err", {15'h0, frame_err}, 16'h0000);
    check("t5_post_rst_busy", {15'h0, busy}, 16'h0000);
    read_chk("t5_post_rst_rd0", 4'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
